// File: rtl/temp_disp_pkg.sv
// Shared constants, FSM encoding and glyph helpers for the temp_seg_display slice.
// Segment glyphs are active-low, bit order g..a.
package temp_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int unsigned DABBLE_ITER = 14;
   localparam logic [9:0]  FRAC_MULT   = 10'd625;

   typedef enum logic [1:0] {
      IDLE,
      ABS,
      DABBLE,
      LOAD
   } state_t;

   function automatic logic [6:0] seg_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0:    g = SEG_0;
         4'h1:    g = SEG_1;
         4'h2:    g = SEG_2;
         4'h3:    g = SEG_3;
         4'h4:    g = SEG_4;
         4'h5:    g = SEG_5;
         4'h6:    g = SEG_6;
         4'h7:    g = SEG_7;
         4'h8:    g = SEG_8;
         4'h9:    g = SEG_9;
         4'hA:    g = SEG_A;
         4'hB:    g = SEG_B;
         4'hC:    g = SEG_C;
         4'hD:    g = SEG_D;
         4'hE:    g = SEG_E;
         default: g = SEG_F;
      endcase
      return g;
   endfunction

   // Constant multiply by FRAC_MULT as a sum of shifted copies (no multiplier).
   function automatic logic [13:0] frac_scale(input logic [3:0] f);
      logic [13:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (FRAC_MULT[i]) acc = acc + (14'(f) << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/temp_seg_display_bin2bcd.sv
// Iterative double-dabble: one adjust+shift per clock, BIN_W clocks per conversion.
// start loads bin_in; done is high in the cycle the final shift is taken.
module bin2bcd_seq #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);

   localparam int unsigned SH_W = DIGITS * 4 + BIN_W;
   localparam int unsigned CW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   logic [SH_W-1:0] sh_q, sh_d, adj;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            run_q, run_d;

   assign done = run_q && (cnt_q == CW'(BIN_W - 1));
   assign bcd  = sh_q[SH_W-1 -: DIGITS*4];

   always_comb begin
      adj = sh_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sh_q[BIN_W + 4*i +: 4] >= 4'd5) adj[BIN_W + 4*i +: 4] = sh_q[BIN_W + 4*i +: 4] + 4'd3;
      end

      sh_d  = sh_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         sh_d  = {{(DIGITS*4){1'b0}}, bin_in};
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         sh_d  = {adj[SH_W-2:0], 1'b0};
         cnt_d = cnt_q + CW'(1);
         if (done) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/temp_seg_display.sv
// ADT7420 temperature word -> signed decimal on a multiplexed 8-digit 7-seg display.
// Optional raw hex view of the last captured word when RAW_HEX_EN is defined.
module temp_seg_display
   import temp_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
`ifdef RAW_HEX_EN
   input  logic        hex_mode,
`endif
   input  logic [15:0] raw_data,
   input  logic        data_valid,
   output logic        busy,
   output logic [7:0]  dig,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t           state_q, state_d;
   logic [12:0]      work_q, work_d;
   logic [12:0]      pend_reg_q, pend_reg_d;
   logic             pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             neg_q, neg_d;
   logic [7:0][6:0]  disp_q, disp_d;
   logic             disp_ok_q, disp_ok_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       dig_q, dig_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

`ifdef RAW_HEX_EN
   logic [15:0]      raw_last_q, raw_last_d;
   logic             raw_ok_q, raw_ok_d;
`else
   logic             unused_raw_lsb;
   assign unused_raw_lsb = ^raw_data[2:0];
`endif

   logic [12:0]      mag;
   logic [13:0]      int_bin, frac_bin;
   logic             cvt_start, int_done, frac_done;
   logic [11:0]      int_bcd;
   logic [15:0]      frac_bcd;

   assign mag       = work_q[12] ? (~work_q + 13'd1) : work_q;
   assign int_bin   = {5'd0, mag[12:4]};
   assign frac_bin  = frac_scale(mag[3:0]);
   assign cvt_start = (state_q == ABS);

   bin2bcd_seq #(.BIN_W(DABBLE_ITER), .DIGITS(3)) u_int_bcd (
      .clk    (clk),
      .rst_n  (rst),
      .start  (cvt_start),
      .bin_in (int_bin),
      .done   (int_done),
      .bcd    (int_bcd)
   );

   bin2bcd_seq #(.BIN_W(DABBLE_ITER), .DIGITS(4)) u_frac_bcd (
      .clk    (clk),
      .rst_n  (rst),
      .start  (cvt_start),
      .bin_in (frac_bin),
      .done   (frac_done),
      .bcd    (frac_bcd)
   );

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      pend_reg_d = pend_reg_q;
      pend_d     = pend_q;
      neg_d      = neg_q;
      disp_d     = disp_q;
      disp_ok_d  = disp_ok_q;

      case (state_q)
         IDLE: begin
            if (data_valid) begin
               work_d  = raw_data[15:3];
               state_d = ABS;
            end
         end
         ABS: begin
            neg_d   = work_q[12] && (mag != '0);
            state_d = DABBLE;
            if (data_valid) begin
               pend_reg_d = raw_data[15:3];
               pend_d     = 1'b1;
            end
         end
         DABBLE: begin
            if (int_done && frac_done) state_d = LOAD;
            if (data_valid) begin
               pend_reg_d = raw_data[15:3];
               pend_d     = 1'b1;
            end
         end
         LOAD: begin
            disp_d[7] = neg_q ? SEG_MINUS : SEG_BLANK;
            disp_d[6] = (int_bcd[11:8] != 4'd0) ? seg_glyph(int_bcd[11:8]) : SEG_BLANK;
            disp_d[5] = (int_bcd[11:4] != 8'd0) ? seg_glyph(int_bcd[7:4]) : SEG_BLANK;
            disp_d[4] = seg_glyph(int_bcd[3:0]);
            disp_d[3] = seg_glyph(frac_bcd[15:12]);
            disp_d[2] = seg_glyph(frac_bcd[11:8]);
            disp_d[1] = seg_glyph(frac_bcd[7:4]);
            disp_d[0] = seg_glyph(frac_bcd[3:0]);
            disp_ok_d = 1'b1;
            // A strobe landing in LOAD is queued behind the pending word, or taken directly.
            if (pend_q) begin
               work_d  = pend_reg_q;
               state_d = ABS;
               if (data_valid) pend_reg_d = raw_data[15:3];
               else            pend_d     = 1'b0;
            end else if (data_valid) begin
               work_d  = raw_data[15:3];
               state_d = ABS;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

`ifdef RAW_HEX_EN
   always_comb begin
      raw_last_d = raw_last_q;
      raw_ok_d   = raw_ok_q;
      if (data_valid) begin
         raw_last_d = raw_data;
         raw_ok_d   = 1'b1;
      end
   end
`endif

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = idx_q + 3'd1;
      end

      dig_d = ~(8'd1 << idx_q);
      seg_d = disp_q[idx_q];
      dp_d  = !(disp_ok_q && (idx_q == 3'd4));
`ifdef RAW_HEX_EN
      if (hex_mode) begin
         dp_d  = 1'b1;
         seg_d = SEG_BLANK;
         if (!idx_q[2] && raw_ok_q) seg_d = seg_glyph(raw_last_q[{idx_q[1:0], 2'b00} +: 4]);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         work_q     <= '0;
         pend_reg_q <= '0;
         pend_q     <= 1'b0;
         busy_q     <= 1'b0;
         neg_q      <= 1'b0;
         disp_q     <= {8{SEG_BLANK}};
         disp_ok_q  <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         dig_q      <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
`ifdef RAW_HEX_EN
         raw_last_q <= '0;
         raw_ok_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         pend_reg_q <= pend_reg_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         neg_q      <= neg_d;
         disp_q     <= disp_d;
         disp_ok_q  <= disp_ok_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         dig_q      <= dig_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
`ifdef RAW_HEX_EN
         raw_last_q <= raw_last_d;
         raw_ok_q   <= raw_ok_d;
`endif
      end
   end

   assign busy = busy_q;
   assign dig  = dig_q;
   assign seg  = seg_q;
   assign dp   = dp_q;

endmodule

// File: tb/tb_temp_seg_display.sv
// Self-checking bench for temp_seg_display (SCAN_DIV=4); expected display text comes
// from an arithmetic model of the temperature value. Covers the RAW_HEX_EN build too.
module tb_temp_seg_display;

   localparam int unsigned SCAN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] raw_data = '0;
   logic        data_valid = 1'b0;
   logic        busy;
   logic [7:0]  dig;
   logic [6:0]  seg;
   logic        dp;
`ifdef RAW_HEX_EN
   logic        hex_mode = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] exp_seg [8];
   logic       exp_dp  [8];
   logic [6:0] obs_seg [8];
   logic       obs_dp  [8];
   logic       obs_seen[8];

   temp_seg_display #(.SCAN_DIV(SCAN)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef RAW_HEX_EN
      .hex_mode   (hex_mode),
`endif
      .raw_data   (raw_data),
      .data_valid (data_valid),
      .busy       (busy),
      .dig        (dig),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
         12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [15:0] v);
      raw_data   = v;
      data_valid = 1'b1;
      tick(1);
      data_valid = 1'b0;
   endtask

   // Count cycles busy stays high (bounded); returns -1 when the bound expires.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick(1);
      end
      if (n >= 200) n = -1;
   endtask

   // Temperature in 1/16 degC units -> expected glyph per digit position.
   task automatic model_decimal(input logic [15:0] raw);
      logic signed [12:0] s;
      int t, mag, ip, fp, h, te, o;
      s   = raw[15:3];
      t   = int'(s);
      mag = (t < 0) ? -t : t;
      ip  = mag / 16;
      fp  = (mag % 16) * 625;
      h   = ip / 100;
      te  = (ip / 10) % 10;
      o   = ip % 10;
      exp_seg[7] = (t < 0) ? 7'h3F : 7'h7F;
      exp_seg[6] = (h != 0) ? glyph(h) : 7'h7F;
      exp_seg[5] = (h != 0 || te != 0) ? glyph(te) : 7'h7F;
      exp_seg[4] = glyph(o);
      exp_seg[3] = glyph(fp / 1000);
      exp_seg[2] = glyph((fp / 100) % 10);
      exp_seg[1] = glyph((fp / 10) % 10);
      exp_seg[0] = glyph(fp % 10);
      for (int d = 0; d < 8; d++) exp_dp[d] = (d != 4);
   endtask

   task automatic read_display();
      int idx;
      for (int d = 0; d < 8; d++) begin
         obs_seen[d] = 1'b0;
         obs_seg[d]  = 'x;
         obs_dp[d]   = 1'bx;
      end
      for (int k = 0; k < 8 * SCAN + 4; k++) begin
         @(negedge clk);
         idx = -1;
         for (int b = 0; b < 8; b++) if (dig === ~(8'd1 << b)) idx = b;
         if (idx >= 0) begin
            obs_seen[idx] = 1'b1;
            obs_seg[idx]  = seg;
            obs_dp[idx]   = dp;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int k, w;
      rst = 1'b0;
      tick(3);
      n_checks++;
      if (dig !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: dig=%h seg=%h dp=%b busy=%b required dig=ff seg=7f dp=1 busy=0", dig, seg, dp, busy);
      end
      rst = 1'b1;
      w = 0;
      @(negedge clk);
      while (dig === 8'hFF && w < 20) begin
         w++;
         @(negedge clk);
      end
      n_checks++;
      if (w >= 20) begin
         n_fail++;
         $display("FAIL scan_start: dig=%h still blank after 20 cycles, required fe", dig);
      end
      for (k = 0; k < 9 * SCAN; k++) begin
         if (k > 0) @(negedge clk);
         n_checks++;
         if (dig !== ~(8'd1 << ((k / SCAN) % 8)) || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_step%0d: dig=%h seg=%h dp=%b required dig=%h seg=7f dp=1",
                     k, dig, seg, dp, ~(8'd1 << ((k / SCAN) % 8)));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [15:0] vals [8];
      int n;
      vals = '{16'h0C80, 16'hE480, 16'h0CF8, 16'h0008, 16'h4B00, 16'h8000, 16'h7FFF, 16'hFFF8};
      for (int v = 0; v < 8; v++) begin
         strobe(vals[v]);
         count_busy(n);
         n_checks++;
         if (n != 16) begin
            n_fail++;
            $display("FAIL busy_len raw=%h: busy cycles=%0d required 16", vals[v], n);
         end
         tick(2);
         read_display();
         model_decimal(vals[v]);
         for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
               n_fail++;
               $display("FAIL directed raw=%h digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                        vals[v], d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      int n;
      for (int r = 0; r < 12; r++) begin
         v = 16'($urandom);
         strobe(v);
         count_busy(n);
         n_checks++;
         if (n != 16) begin
            n_fail++;
            $display("FAIL busy_len_rand raw=%h: busy cycles=%0d required 16", v, n);
         end
         tick(2);
         read_display();
         model_decimal(v);
         for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
               n_fail++;
               $display("FAIL random raw=%h digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                        v, d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      strobe(16'h0C80);
      tick(2);
      strobe(16'h4B00);
      tick(1);
      strobe(16'hE480);
      // Two conversions (32 busy cycles) measured from the first strobe; 5 have elapsed.
      count_busy(n);
      n_checks++;
      if (n != 27) begin
         n_fail++;
         $display("FAIL back_to_back_busy: busy cycles=%0d required 27", n);
      end
      tick(2);
      read_display();
      model_decimal(16'hE480);
      for (int d = 0; d < 8; d++) begin
         n_checks++;
         if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
            n_fail++;
            $display("FAIL back_to_back digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                     d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      strobe(16'h0C80);
      tick(5);
      rst = 1'b0;
      #1;
      n_checks++;
      if (dig !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: dig=%h seg=%h dp=%b busy=%b required dig=ff seg=7f dp=1 busy=0", dig, seg, dp, busy);
      end
      tick(2);
      rst = 1'b1;
      tick(20);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: busy=%b required 0", busy);
      end
      read_display();
      for (int d = 0; d < 8; d++) begin
         n_checks++;
         if (!obs_seen[d] || obs_seg[d] !== 7'h7F || obs_dp[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_blank digit%0d: seg=%h dp=%b required seg=7f dp=1",
                     d, obs_seg[d], obs_dp[d]);
         end
      end
      strobe(16'h0C88);
      count_busy(n);
      tick(2);
      read_display();
      model_decimal(16'h0C88);
      for (int d = 0; d < 8; d++) begin
         n_checks++;
         if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
            n_fail++;
            $display("FAIL reset_mid_after digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                     d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
         end
      end
   endtask

`ifdef RAW_HEX_EN
   task automatic test_hex_mode();
      int n;
      logic [15:0] v;
      v = 16'hE480;
      hex_mode = 1'b1;
      strobe(v);
      count_busy(n);
      tick(2);
      read_display();
      for (int d = 0; d < 8; d++) begin
         exp_seg[d] = (d < 4) ? glyph(int'((v >> (4 * d)) & 16'hF)) : 7'h7F;
         exp_dp[d]  = 1'b1;
      end
      for (int d = 0; d < 8; d++) begin
         n_checks++;
         if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
            n_fail++;
            $display("FAIL hex_view digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                     d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
         end
      end
      hex_mode = 1'b0;
      tick(2);
      read_display();
      model_decimal(v);
      for (int d = 0; d < 8; d++) begin
         n_checks++;
         if (!obs_seen[d] || obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
            n_fail++;
            $display("FAIL hex_off digit%0d: seg=%h dp=%b required seg=%h dp=%b",
                     d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef RAW_HEX_EN
      test_hex_mode();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/temp_seg_display.md
Name: temp_seg_display

Overview:
- Sits directly downstream of the ADT7420 I2C read driver.
- Accepts each new 16-bit temperature word, converts it to signed decimal with a sequential double-dabble, and time-multiplexes the result onto the board's 8-digit 7-segment display.
- Format: sign, 3 integer digits, decimal point, 4 fraction digits, at 0.0625 °C resolution.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- raw_data  in  16  ADT7420 temperature register; [15:3] is 13-bit two's complement, LSB = 0.0625 °C; [2:0] ignored
- data_valid  in  1  one-cycle strobe; raw_data is valid in that cycle
- busy  out  1  conversion in progress
- dig  out  8  digit enables, active-low, one-cold; bit 7 = leftmost digit
- seg  out  7  segments g..a, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (rst low, async):
  - dig=8'hFF, seg=7'h7F, dp=1, busy=0.
  - Display registers are set to BLANK; pending flag cleared; FSM goes to IDLE; scan counter=0; digit index=0.
- Capture:
  - data_valid in IDLE latches raw_data into work_reg; next state ABS; busy=1 from the next cycle.
  - data_valid while busy latches raw_data into pend_reg and sets pend. A later strobe overwrites pend_reg, so only the newest pending value is kept.
- FSM states:
  - IDLE
  - ABS (1 cycle): sign=work[15]; mag=|work[15:3]| as 13 bits unsigned; int_bin=mag[12:4] (9 bits); frac_bin=mag[3:0]*625 (14 bits, max 9375), computed by shift-add.
  - DABBLE (14 cycles, counter 0..13): integer and fraction shifters run in lockstep. int_bin is zero-extended to 14 bits. Each cycle: add 3 to every BCD nibble ≥5, then shift left 1.
  - LOAD (1 cycle): copy BCD results and sign into display registers; clear busy. If pend is set, move pend_reg into work_reg, clear pend, and go to ABS (busy stays 1). Otherwise go to IDLE.
- Latency: display registers update at the clk edge 17 cycles after the data_valid edge (1 ABS + 14 DABBLE + 1 LOAD + capture).
- Display mapping:
  - digit7: '-' if sign and magnitude ≠ 0, else blank.
  - digit6: hundreds; blank if 0.
  - digit5: tens; blank if hundreds=0 and tens=0.
  - digit4: ones, always shown, dp lit.
  - digits 3..0: fraction, always shown.
- Edge cases:
  - 13'h1000 (-256.0000) gives magnitude 256, shown "-256.0000".
  - raw [2:0] never affects the output.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, digit index increments 0..7 and wraps 7→0.
  - dig = ~(1<<index). seg and dp are registered in the same cycle as dig, so there is no glyph/enable skew.
  - Scanning runs independently of conversion. The display registers change only in LOAD, so a digit never shows a half-converted value.
- Reset mid-conversion discards work_reg and pend_reg. The display stays blank until a new data_valid completes.

Optional Feature:
- RAW_HEX_EN defined:
  - Adds input port hex_mode (1 bit, synchronous level).
  - When high, digits 3..0 show the last captured raw_data in hex (0-9, A-F glyphs), digits 7..4 are blank, and dp is off. Conversion still runs, so dropping hex_mode immediately shows the decimal value.
- Undefined: port absent; decimal display only.

Decomposition:
- Package temp_disp_pkg holds:
  - 7-seg glyph constants SEG_0..SEG_F, SEG_MINUS, SEG_BLANK.
  - FSM state encoding (IDLE, ABS, DABBLE, LOAD).
  - DABBLE_ITER=14 and FRAC_MULT=625.
- Sub-module bin2bcd_seq: generic-width iterative double-dabble with start/done handshake, instantiated twice (integer and fraction). The scan and glyph logic stays in the top module.

Test Plan:
- Reset, SCAN_DIV=4: dig steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles and wraps; seg=7F on every digit.
- raw 16'h0C80 strobed → busy high for 16 cycles; display " 25.0000" (digit4 '5' with dp=0, digit6 blank, digit7 blank).
- raw 16'hE480 → "- 55.0000"; raw 16'h0CF8 → " 25.9375"; raw 16'h0008 → "   0.0625"; raw 16'h4B00 → " 150.0000".
- raw 16'h0C80, then 16'h4B00 at +3 cycles, then 16'hE480 at +5 cycles → display shows 25.0000, then -55.0000 (16'h4B00 overwritten in pend); busy stays high across both conversions.
- rst low 6 cycles after data_valid → dig=FF, seg=7F, busy=0 immediately. After release the display stays blank until the next strobe; the following strobe of 16'h0C88 shows " 25.0625".
- RAW_HEX_EN with hex_mode=1, raw 16'hE480 → digits 3..0 show "E480", digits 7..4 blank; hex_mode→0 → "- 55.0000" with no new strobe.
